// File: rtl/string_accel_master.sv
// string_accel_master: Avalon-MM master that loads the string accelerator from memory,
// starts it, polls done and copies Result out. Optional: STRING_ACCEL_MASTER_TIMEOUT_EN.
module string_accel_master #(
  parameter int unsigned MAX_BLOCKS    = 2,
  parameter logic [31:0] ACCEL_BASE    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_src_a,
  input  logic [31:0] cmd_src_b,
  input  logic [31:0] cmd_dst,
  input  logic [3:0]  cmd_index,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);
  localparam int unsigned KW = $clog2(2*MAX_BLOCKS + 1);

  if (MAX_BLOCKS == 0 || TIMEOUT_POLLS == 0) begin : g_param_check
    $error("string_accel_master: MAX_BLOCKS and TIMEOUT_POLLS must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE, LOAD_RD, LOAD_WAIT, LOAD_WR, START,
    POLL_RD, POLL_WAIT, RES_RD, RES_WAIT, RES_WR, CLEAR
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [31:0]   src_a;
  logic [31:0]   src_b;
  logic [31:0]   dst;
  logic [3:0]    index;

`ifdef STRING_ACCEL_MASTER_TIMEOUT_EN
  localparam int unsigned PW = $clog2(TIMEOUT_POLLS + 1);
  logic [PW-1:0] polls;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = ~busy;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [KW-1:0] w);
    return base + (32'(w) << 2);
  endfunction

  // Operand word w comes from StringA for the first MAX_BLOCKS words, then StringB.
  function automatic logic [31:0] load_addr(input logic [31:0] a, input logic [31:0] b,
                                            input logic [KW-1:0] w);
    if (w < KW'(MAX_BLOCKS)) return word_addr(a, w);
    return word_addr(b, w - KW'(MAX_BLOCKS));
  endfunction

  function automatic logic [31:0] ctrl_go(input logic [3:0] idx);
    return {26'd0, idx, 2'b10};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      k             <= '0;
`ifdef STRING_ACCEL_MASTER_TIMEOUT_EN
      err_q         <= 1'b0;
      polls         <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          src_a       <= cmd_src_a;
          src_b       <= cmd_src_b;
          dst         <= cmd_dst;
          index       <= cmd_index;
          busy        <= 1'b1;
          k           <= '0;
          avm_read    <= 1'b1;
          avm_address <= cmd_src_a;
          state       <= LOAD_RD;
`ifdef STRING_ACCEL_MASTER_TIMEOUT_EN
          err_q       <= 1'b0;
`endif
        end
        LOAD_RD: if (!avm_waitrequest) begin
          avm_read <= 1'b0;
          state    <= LOAD_WAIT;
        end
        LOAD_WAIT: if (avm_readdatavalid) begin
          avm_write     <= 1'b1;
          avm_address   <= word_addr(ACCEL_BASE, k + KW'(1));
          avm_writedata <= avm_readdata;
          state         <= LOAD_WR;
        end
        LOAD_WR: if (!avm_waitrequest) begin
          if (k == KW'(2*MAX_BLOCKS - 1)) begin
            avm_address   <= ACCEL_BASE;
            avm_writedata <= ctrl_go(index);
            state         <= START;
          end else begin
            avm_write   <= 1'b0;
            avm_read    <= 1'b1;
            k           <= k + KW'(1);
            avm_address <= load_addr(src_a, src_b, k + KW'(1));
            state       <= LOAD_RD;
          end
        end
        START: if (!avm_waitrequest) begin
          avm_write   <= 1'b0;
          avm_read    <= 1'b1;
          avm_address <= ACCEL_BASE;
          state       <= POLL_RD;
`ifdef STRING_ACCEL_MASTER_TIMEOUT_EN
          polls       <= '0;
`endif
        end
        POLL_RD: if (!avm_waitrequest) begin
          avm_read <= 1'b0;
          state    <= POLL_WAIT;
`ifdef STRING_ACCEL_MASTER_TIMEOUT_EN
          polls    <= polls + PW'(1);
`endif
        end
        POLL_WAIT: if (avm_readdatavalid) begin
          if (avm_readdata[0]) begin
            k           <= '0;
            avm_read    <= 1'b1;
            avm_address <= word_addr(ACCEL_BASE, KW'(1));
            state       <= RES_RD;
          end else begin
`ifdef STRING_ACCEL_MASTER_TIMEOUT_EN
            if (polls == PW'(TIMEOUT_POLLS)) begin
              err_q         <= 1'b1;
              avm_write     <= 1'b1;
              avm_address   <= ACCEL_BASE;
              avm_writedata <= '0;
              state         <= CLEAR;
            end else begin
              avm_read <= 1'b1;
              state    <= POLL_RD;
            end
`else
            avm_read <= 1'b1;
            state    <= POLL_RD;
`endif
          end
        end
        RES_RD: if (!avm_waitrequest) begin
          avm_read <= 1'b0;
          state    <= RES_WAIT;
        end
        RES_WAIT: if (avm_readdatavalid) begin
          avm_write     <= 1'b1;
          avm_address   <= word_addr(dst, k);
          avm_writedata <= avm_readdata;
          state         <= RES_WR;
        end
        RES_WR: if (!avm_waitrequest) begin
          if (k == KW'(MAX_BLOCKS - 1)) begin
            avm_address   <= ACCEL_BASE;
            avm_writedata <= '0;
            state         <= CLEAR;
          end else begin
            avm_write   <= 1'b0;
            avm_read    <= 1'b1;
            k           <= k + KW'(1);
            avm_address <= word_addr(ACCEL_BASE, k + KW'(2));
            state       <= RES_RD;
          end
        end
        CLEAR: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_string_accel_master.sv
// tb_string_accel_master: randomized bench with an Avalon memory/accelerator slave model
// and a transaction-level reference of the bus writes each command must produce.
`timescale 1ns/1ps
module tb_string_accel_master;
  localparam int          MB      = 2;
  localparam logic [31:0] ACCEL   = 32'hF000_0000;
  localparam int          TPOLLS  = 4;
  localparam int          LAT_MIN = 3*2*MB + 1 + 2*1 + 3*MB + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic [3:0]  cmd_index = '0;
  logic        busy, done, err;
  logic [31:0] avm_address, avm_writedata;
  logic        avm_read, avm_write;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  string_accel_master #(.MAX_BLOCKS(MB), .ACCEL_BASE(ACCEL), .TIMEOUT_POLLS(TPOLLS)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_index(cmd_index),
    .busy(busy), .done(done), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave-side configuration and state
  int unsigned stall_max = 0, rdv_max = 1, accel_delay = 5;
  bit          never_done = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] acc_a [MB];
  logic [31:0] acc_b [MB];
  logic        acc_go = 1'b0, acc_done = 1'b0;
  logic [3:0]  acc_idx = '0;
  int unsigned acc_cnt = 0;
  logic [63:0] wr_log [$];
  int ctrl_reads = 0, res_reads = 0;
  int viol_stable = 0, viol_both = 0, viol_outst = 0;
  int done_cnt = 0, acc_cmds = 0, done_acc = 0, last_accept_edge = 0, last_done_edge = 0;
  logic last_done_err = 1'b0, prev_busy = 1'b0;

  function automatic logic [31:0] res_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] idx);
    return (a ^ b) + {28'd0, idx};
  endfunction

  function automatic bit in_accel(input logic [31:0] addr);
    return (addr >= ACCEL) && (addr < ACCEL + 32'(4*(2*MB+1)));
  endfunction

  task automatic slave_write(input logic [31:0] addr, input logic [31:0] data);
    int unsigned w;
    wr_log.push_back({addr, data});
    if (in_accel(addr)) begin
      w = (addr - ACCEL) >> 2;
      if (w == 0) begin
        acc_go   = data[1];
        acc_idx  = data[5:2];
        acc_cnt  = accel_delay;
        acc_done = data[1] && (accel_delay == 0) && !never_done;
      end else if (w <= MB) acc_a[w-1] = data;
      else acc_b[w-MB-1] = data;
    end else mem[addr] = data;
  endtask

  function automatic logic [31:0] slave_read(input logic [31:0] addr);
    int unsigned w;
    if (in_accel(addr)) begin
      w = (addr - ACCEL) >> 2;
      if (w == 0) begin
        ctrl_reads++;
        return {26'd0, acc_idx, acc_go, acc_done};
      end
      if (w <= MB) begin
        res_reads++;
        return acc_done ? res_fn(acc_a[w-1], acc_b[w-1], acc_idx) : 32'hDEAD_BEEF;
      end
      return 32'hBAD0_0000;
    end
    return mem.exists(addr) ? mem[addr] : 32'd0;
  endfunction

  // Bus slave and monitor, all decisions at the falling edge
  initial begin
    int unsigned rd_cnt = 0, stall = 0;
    logic [31:0] rd_data = '0;
    bit          rd_out = 1'b0, in_req = 1'b0;
    logic [65:0] snap = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_acc = acc_cmds;
        last_done_edge = cyc;
        last_done_err = err;
      end
      if (busy && !prev_busy) begin
        acc_cmds++;
        last_accept_edge = cyc;
      end
      prev_busy = busy;
      if (acc_go && !acc_done && !never_done && acc_cnt > 0) begin
        acc_cnt--;
        if (acc_cnt == 0) acc_done = 1'b1;
      end
      if (reset) begin
        rd_cnt = 0; rd_out = 1'b0; in_req = 1'b0; stall = 0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
      end else begin
        avm_readdatavalid = 1'b0;
        if (stall_max > 0) avm_readdata = $urandom;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = rd_data;
          end
        end
        if (avm_read && avm_write) viol_both++;
        if (avm_read && rd_out) viol_outst++;
        if (avm_readdatavalid) rd_out = 1'b0;
        avm_waitrequest = 1'b0;
        if (avm_read || avm_write) begin
          if (!in_req) begin
            in_req = 1'b1;
            stall = $urandom_range(stall_max, 0);
            snap = {avm_address, avm_writedata, avm_read, avm_write};
          end else if ({avm_address, avm_writedata, avm_read, avm_write} !== snap) viol_stable++;
          if (stall > 0) begin
            stall--;
            avm_waitrequest = 1'b1;
          end else begin
            in_req = 1'b0;
            if (avm_write) slave_write(avm_address, avm_writedata);
            else begin
              rd_data = slave_read(avm_address);
              rd_cnt = $urandom_range(rdv_max, 1);
              rd_out = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic wait_acc(input int target, input string tag);
    int n = 0;
    while (acc_cmds < target && n < 200) begin @(negedge clk); n++; end
    if (acc_cmds < target) check({tag, "_accept_timeout"}, 64'(acc_cmds), 64'(target));
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge clk); n++; end
    if (done_cnt < target) check({tag, "_done_timeout"}, 64'(done_cnt), 64'(target));
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                           input logic [3:0] idx);
    @(negedge clk);
    cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_index = idx;
    cmd_valid = 1'b1;
  endtask

  task automatic rand_operands(output logic [31:0] a, output logic [31:0] b,
                               output logic [31:0] d, output logic [3:0] idx);
    a = 32'h0100_0000 | ($urandom & 32'h00FF_FFFC);
    b = 32'h0200_0000 | ($urandom & 32'h00FF_FFFC);
    d = 32'h0300_0000 | ($urandom & 32'h00FF_FFFC);
    idx = 4'($urandom);
    for (int w = 0; w < MB; w++) begin
      mem[a + 32'(4*w)] = $urandom;
      mem[b + 32'(4*w)] = $urandom;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic [3:0] idx, input bit tmo,
                         output int lat);
    logic [63:0] expq [$];
    int base_acc, base_done;
    for (int i = 0; i < 2*MB; i++)
      expq.push_back({ACCEL + 32'(4*(i+1)),
                      (i < MB) ? mem[a + 32'(4*i)] : mem[b + 32'(4*(i-MB))]});
    expq.push_back({ACCEL, 26'd0, idx, 2'b10});
    if (!tmo)
      for (int w = 0; w < MB; w++)
        expq.push_back({d + 32'(4*w), res_fn(mem[a + 32'(4*w)], mem[b + 32'(4*w)], idx)});
    expq.push_back({ACCEL, 32'd0});
    wr_log.delete();
    ctrl_reads = 0; res_reads = 0; viol_stable = 0; viol_both = 0; viol_outst = 0;
    base_acc = acc_cmds;
    base_done = done_cnt;
    start_cmd(a, b, d, idx);
    wait_acc(base_acc + 1, tag);
    cmd_valid = 1'b0;
    check({tag, "_err_clear"}, 64'(err), 64'(0));
    wait_done(base_done + 1, tag);
    lat = last_done_edge - last_accept_edge;
    @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - base_done), 64'(1));
    check({tag, "_err"}, 64'(last_done_err), 64'(tmo));
    check({tag, "_nwr"}, 64'(wr_log.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < wr_log.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_log[i], expq[i]);
    check({tag, "_bus_viol"}, 64'(viol_stable + viol_both + viol_outst), 64'(0));
    check({tag, "_res_reads"}, 64'(res_reads), 64'(tmo ? 0 : MB));
    if (tmo) check({tag, "_ctrl_reads"}, 64'(ctrl_reads), 64'(TPOLLS));
    else begin
      check({tag, "_polled"}, 64'(ctrl_reads > 0), 64'(1));
      for (int w = 0; w < MB; w++)
        check($sformatf("%s_dst%0d", tag, w), 64'(mem[d + 32'(4*w)]),
              64'(res_fn(mem[a + 32'(4*w)], mem[b + 32'(4*w)], idx)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n, base_acc, base_done;
    logic [31:0] a, b, d;
    logic [3:0]  idx;
    logic [31:0] r0 [MB];

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_read", 64'(avm_read), 64'(0));
    check("rst_write", 64'(avm_write), 64'(0));
    check("rst_addr", 64'(avm_address), 64'(0));
    check("rst_wdata", 64'(avm_writedata), 64'(0));
    reset = 1'b0;

    a = 32'h0000_1000; b = 32'h0000_2000; d = 32'h0000_3000;
    mem[a] = 32'h6C6C_6548; mem[a + 4] = 32'h0000_006F;
    mem[b] = 32'h6C72_6F57; mem[b + 4] = 32'h0000_0064;
    accel_delay = 5;
    run_cmd("hello", a, b, d, 4'd3, 1'b0, lat);

    accel_delay = 0;
    rand_operands(a, b, d, idx);
    run_cmd("lat", a, b, d, idx, 1'b0, lat);
    check("latency", 64'(lat), 64'(LAT_MIN));

    stall_max = 4; rdv_max = 3;
    for (int i = 0; i < 5; i++) begin
      accel_delay = $urandom_range(8, 0);
      rand_operands(a, b, d, idx);
      run_cmd($sformatf("rnd%0d", i), a, b, d, idx, 1'b0, lat);
    end

    stall_max = 0; rdv_max = 1; accel_delay = 2;
    rand_operands(a, b, d, idx);
    run_cmd("img_ref", a, b, d, idx, 1'b0, lat);
    for (int w = 0; w < MB; w++) begin
      r0[w] = mem[d + 32'(4*w)];
      mem[d + 32'(4*w)] = '0;
    end
    stall_max = 4; rdv_max = 3;
    run_cmd("img_stall", a, b, d, idx, 1'b0, lat);
    for (int w = 0; w < MB; w++)
      check($sformatf("img_same%0d", w), 64'(mem[d + 32'(4*w)]), 64'(r0[w]));

    stall_max = 0; rdv_max = 1; accel_delay = 3;
    rand_operands(a, b, d, idx);
    base_acc = acc_cmds;
    base_done = done_cnt;
    start_cmd(a, b, d, idx);
    wait_acc(base_acc + 2, "hold");
    cmd_valid = 1'b0;
    check("hold_single_accept", 64'(done_acc - base_acc), 64'(1));
    check("hold_next_edge", 64'(last_accept_edge), 64'(last_done_edge + 1));
    wait_done(base_done + 2, "hold");
    @(negedge clk);
    check("hold_dones", 64'(done_cnt - base_done), 64'(2));
    check("hold_err", 64'(last_done_err), 64'(0));

    accel_delay = 30;
    rand_operands(a, b, d, idx);
    ctrl_reads = 0;
    base_acc = acc_cmds;
    start_cmd(a, b, d, idx);
    wait_acc(base_acc + 1, "rst");
    cmd_valid = 1'b0;
    n = 0;
    while (!(ctrl_reads > 0 && avm_read) && n < 500) begin @(negedge clk); n++; end
    check("rst_in_poll", 64'(ctrl_reads > 0 && avm_read), 64'(1));
    reset = 1'b1;
    base_done = done_cnt;
    @(negedge clk);
    check("rst_mid_read", 64'(avm_read), 64'(0));
    check("rst_mid_write", 64'(avm_write), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_done", 64'(done_cnt), 64'(base_done));
    accel_delay = 4;
    rand_operands(a, b, d, idx);
    run_cmd("post_rst", a, b, d, idx, 1'b0, lat);

`ifdef STRING_ACCEL_MASTER_TIMEOUT_EN
    never_done = 1'b1;
    rand_operands(a, b, d, idx);
    run_cmd("tmo", a, b, d, idx, 1'b1, lat);
    check("tmo_err_held", 64'(err), 64'(1));
    never_done = 1'b0;
    rand_operands(a, b, d, idx);
    run_cmd("after_tmo", a, b, d, idx, 1'b0, lat);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/string_accel_master.md
# string_accel_master

Avalon-MM master that drives the string hardware accelerator's register map from memory-resident operands. Given source addresses for StringA and StringB, a destination address and an index, it fetches the operand words over its master port and writes them into the accelerator's A/B registers. It then sets go, polls the done bit, reads the Result words and writes them to the destination buffer. It is the initiator counterpart of the accelerator's Avalon slave and sits between the system interconnect and that slave, replacing CPU-driven register loading.

## Interface
Parameters:
- MAX_BLOCKS, 2, number of 32-bit words per string; must match the accelerator.
- ACCEL_BASE, 32'h0000_0000, byte base address of the accelerator slave.
- TIMEOUT_POLLS, 1024, maximum done-poll reads; used only when the timeout feature is compiled in.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_src_a  in  32  byte address of StringA, word aligned
- cmd_src_b  in  32  byte address of StringB, word aligned
- cmd_dst  in  32  byte address of Result buffer, word aligned
- cmd_index  in  4  index field for control bits [5:2]
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag, cleared on the next command accept
- avm_address  out  32  byte address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data strobe

## Operation
- Accelerator word map, byte address = ACCEL_BASE + 4·w:
  - w=0: control. Bit0 is done (read). Bit1 is go. Bits[5:2] are index.
  - w=1..MAX_BLOCKS: StringA on write, Result on read when done=1.
  - w=MAX_BLOCKS+1..2·MAX_BLOCKS: StringB.
- IDLE: when cmd_valid and cmd_ready are both high, latch all cmd_* fields, clear err, set busy, clear word counter k, and go to LOAD.
- LOAD, k=0..2·MAX_BLOCKS−1:
  - Read from cmd_src_a+4k for k<MAX_BLOCKS, otherwise from cmd_src_b+4(k−MAX_BLOCKS).
  - Write the returned word to accelerator word k+1.
  - After the last word, go to START.
- START: write control = {26'b0, cmd_index, 1'b1, 1'b0}, then go to POLL.
- POLL:
  - Read control.
  - If readdata[0]=1, clear k and go to RESULT.
  - Otherwise re-issue the read.
- RESULT, k=0..MAX_BLOCKS−1: read accelerator word k+1 and write it to cmd_dst+4k. After the last word, go to CLEAR.
- CLEAR: write control = 0, which drops go. Then pulse done for one cycle, deassert busy and return to IDLE.
- Each transfer is a single access with at most one read outstanding. No bursts.

## Timing
- Reset values: all outputs are 0 except cmd_ready=1. State is IDLE.
- Reset mid-operation aborts on the next edge: avm_read and avm_write drop immediately, the latched command is discarded, and done is not pulsed.
- While avm_waitrequest=1, avm_address, avm_read, avm_write and avm_writedata are held stable.
- A request is accepted in the cycle avm_read or avm_write is high with avm_waitrequest=0.
- Read data is captured only on avm_readdatavalid, at the earliest one cycle after acceptance. The next request is not issued before the readdatavalid is seen.
- avm_read and avm_write are never high together.
- A write request is issued in the cycle after the corresponding readdatavalid.
- Minimum latency, with zero wait states, readdatavalid one cycle after accept and P polls:
  - Command accept to done pulse = 3·2·MAX_BLOCKS + 1 + 2P + 3·MAX_BLOCKS + 1 cycles.
  - For MAX_BLOCKS=2 and P=1 this is 22 cycles.
- cmd_valid is ignored while busy. cmd_ready and busy are complementary.
- Address arithmetic is 32-bit modulo 2^32. Wrap-around is not flagged.

## Configuration
- STRING_ACCEL_MASTER_TIMEOUT_EN defined:
  - A poll counter cleared on entry to POLL counts issued control reads.
  - If TIMEOUT_POLLS reads all return done=0, set err=1, skip RESULT and go to CLEAR. CLEAR writes 0 and pulses done.
  - If done=1 is seen on read number TIMEOUT_POLLS, this counts as success.
- Not defined: POLL waits indefinitely and err is tied to 0.

## Test plan
- MAX_BLOCKS=2, src_a words {0x6C6C6548,0x0000006F}, src_b words {0x6C726F57,0x00000064}, index=3, accelerator model asserts done after 5 cycles -> writes seen in order at words 1,2,3,4 with those values, then control=0x0000000E, then dst receives the model's Result words, then control=0; done pulses once; err=0.
- Random avm_waitrequest stalls of 0–4 cycles and readdatavalid delay of 1–3 cycles -> address, data and read/write stay stable during stalls, never more than one read outstanding, and the final memory image is identical to the zero-wait run.
- cmd_valid held high through a command -> exactly one command accepted; a second command is accepted only on the cycle after the done pulse.
- Reset asserted during POLL -> next cycle avm_read=0, busy=0, cmd_ready=1, no done pulse; a new command then completes normally.
- Timeout build, TIMEOUT_POLLS=4, accelerator never sets done -> exactly 4 control reads, no Result reads, control=0 written, done pulse with err=1; err clears on the next accept.
- Zero-wait timing, done returned on the first poll -> done pulse exactly 22 cycles after accept.
